matrix3_scan_controller: RTL

MATRIX3_SCAN_CONTROLLER -- requirements
Module: matrix3_scan_controller

---
 rtl/matrix3_scan_pkg.sv | 19 +
 rtl/matrix3_scan_counter.sv | 56 +++++
 rtl/matrix3_scan_controller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/matrix3_scan_pkg.sv
// Shared state encodings and sizing helpers for the 3x3 matrix scan controller.
// Optional center-tag outputs are enabled by MATRIX3_SCAN_CENTER_TAG_EN.
package matrix3_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WRITE = 2'b01,
        S_READ  = 2'b10,
        S_DRAIN = 2'b11
    } scan_state_e;

    localparam scan_state_e STATE_AFTER_RESET = S_IDLE;

    // A single-entry dimension still needs a one-bit address so ports never collapse.
    function automatic int unsigned addrWidth(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/matrix3_scan_counter.sv
// Raster row/column counter used by both the write and the read phase of the scan controller.
// It wraps back to (0,0) after the last position.
module matrix3_scan_counter #(
    parameter int unsigned P_COLUMNS   = 640,
    parameter int unsigned P_ROWS      = 4,
    parameter int unsigned P_COL_WIDTH = 10,
    parameter int unsigned P_ROW_WIDTH = 2
) (
    input  logic                   I_CLK,
    input  logic                   I_RESET,
    input  logic                   I_ENABLE,
    input  logic                   I_CLEAR,
    output logic [P_COL_WIDTH-1:0] O_COLUMN,
    output logic [P_ROW_WIDTH-1:0] O_ROW,
    output logic                   O_LAST
);

    logic [P_COL_WIDTH-1:0] column_q, column_d;
    logic [P_ROW_WIDTH-1:0] row_q, row_d;
    logic                   columnLast;
    logic                   rowLast;

    assign columnLast = (column_q == P_COL_WIDTH'(P_COLUMNS - 1));
    assign rowLast    = (row_q == P_ROW_WIDTH'(P_ROWS - 1));

    always_comb begin
        column_d = column_q;
        row_d    = row_q;
        if (I_CLEAR) begin
            column_d = '0;
            row_d    = '0;
        end else if (I_ENABLE) begin
            if (columnLast) begin
                column_d = '0;
                row_d    = rowLast ? '0 : row_q + 1'b1;
            end else begin
                column_d = column_q + 1'b1;
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            column_q <= '0;
            row_q    <= '0;
        end else begin
            column_q <= column_d;
            row_q    <= row_d;
        end
    end

    assign O_COLUMN = column_q;
    assign O_ROW    = row_q;
    assign O_LAST   = columnLast && rowLast;

endmodule

// File: rtl/matrix3_scan_controller.sv
// Loads one frame-buffer tile in raster order, then scans it out as 3x3 neighbourhoods with valid/ready flow control.
// Define MATRIX3_SCAN_CENTER_TAG_EN to add the O_CENTER_ROW/O_CENTER_COLUMN outputs.
module matrix3_scan_controller
    import matrix3_scan_pkg::*;
#(
    parameter int unsigned P_COLUMNS     = 640,
    parameter int unsigned P_ROWS        = 4,
    parameter int unsigned P_PIXEL_DEPTH = 8
) (
    input  logic                                I_CLK,
    input  logic                                I_RESET,
    input  logic                                I_START,
    input  logic [P_PIXEL_DEPTH-1:0]            I_PIXEL,
    input  logic                                I_PIXEL_VALID,
    output logic                                O_PIXEL_READY,
    input  logic                                I_MATRIX_READY,
    output logic [addrWidth(P_COLUMNS)-1:0]     O_BUF_COLUMN,
    output logic [addrWidth(P_ROWS)-1:0]        O_BUF_ROW,
    output logic [P_PIXEL_DEPTH-1:0]            O_BUF_PIXEL,
    output logic                                O_BUF_WRITE_ENABLE,
    output logic                                O_BUF_READ_ENABLE,
    output logic                                O_MATRIX_VALID,
    output logic                                O_DONE,
    output logic                                O_BUSY
`ifdef MATRIX3_SCAN_CENTER_TAG_EN
    ,
    output logic [addrWidth(P_ROWS)-1:0]        O_CENTER_ROW,
    output logic [addrWidth(P_COLUMNS)-1:0]     O_CENTER_COLUMN
`endif
);

    localparam int unsigned COL_W = addrWidth(P_COLUMNS);
    localparam int unsigned ROW_W = addrWidth(P_ROWS);

    scan_state_e      state_q, state_d;
    logic             matrixValid_q, matrixValid_d;
    logic             done_q, done_d;
    logic [COL_W-1:0] counterColumn;
    logic [ROW_W-1:0] counterRow;
    logic             counterLast;
    logic             writeFire;
    logic             readFire;
    logic             counterClear;

    assign writeFire    = (state_q == S_WRITE) && I_PIXEL_VALID;
    assign readFire     = (state_q == S_READ) && (!matrixValid_q || I_MATRIX_READY);
    assign counterClear = (state_q == S_IDLE) && I_START;

    matrix3_scan_counter #(
        .P_COLUMNS  (P_COLUMNS),
        .P_ROWS     (P_ROWS),
        .P_COL_WIDTH(COL_W),
        .P_ROW_WIDTH(ROW_W)
    ) u_counter (
        .I_CLK   (I_CLK),
        .I_RESET (I_RESET),
        .I_ENABLE(writeFire || readFire),
        .I_CLEAR (counterClear),
        .O_COLUMN(counterColumn),
        .O_ROW   (counterRow),
        .O_LAST  (counterLast)
    );

    // A read issued in the same cycle as a consume keeps the matrix valid, giving one matrix per cycle.
    always_comb begin
        state_d       = state_q;
        matrixValid_d = matrixValid_q;
        done_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (I_START) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (writeFire && counterLast) state_d = S_READ;
            end
            S_READ: begin
                if (readFire) matrixValid_d = 1'b1;
                else if (matrixValid_q && I_MATRIX_READY) matrixValid_d = 1'b0;
                if (readFire && counterLast) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!matrixValid_q || I_MATRIX_READY) begin
                    matrixValid_d = 1'b0;
                    done_d        = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q       <= STATE_AFTER_RESET;
            matrixValid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            matrixValid_q <= matrixValid_d;
            done_q        <= done_d;
        end
    end

`ifdef MATRIX3_SCAN_CENTER_TAG_EN
    logic [ROW_W-1:0] centerRow_q;
    logic [COL_W-1:0] centerColumn_q;

    // The tag follows the matrix it names, so it is captured with the read that fetches it.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            centerRow_q    <= '0;
            centerColumn_q <= '0;
        end else if (readFire) begin
            centerRow_q    <= counterRow;
            centerColumn_q <= counterColumn;
        end
    end

    assign O_CENTER_ROW    = centerRow_q;
    assign O_CENTER_COLUMN = centerColumn_q;
`endif

    assign O_PIXEL_READY      = (state_q == S_WRITE);
    assign O_BUF_WRITE_ENABLE = writeFire;
    assign O_BUF_READ_ENABLE  = readFire;
    assign O_BUF_PIXEL        = (state_q == S_WRITE) ? I_PIXEL : '0;
    assign O_BUF_COLUMN       = counterColumn;
    assign O_BUF_ROW          = counterRow;
    assign O_MATRIX_VALID     = matrixValid_q;
    assign O_DONE             = done_q;
    assign O_BUSY             = (state_q != S_IDLE);

endmodule
